// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one block-memory port between the I-cache refill path and the
//   D-cache refill/writeback path. One block transfer is in flight at a time.
//   The winner's address and data are latched in IDLE, the memory strobes are
//   re-driven from registers, and a read block is returned to the owner's
//   readdata register when memory completes.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     undefined : fixed priority, the D-cache wins simultaneous requests
//     defined   : simultaneous requests go to the side not granted last
//
// Ports
//   clk, reset                     rising-edge clock, async active-high reset
//   i_read, i_address              I-cache block read request
//   i_readdata, i_busywait         block returned to I-cache, I-cache stall
//   d_read, d_write, d_address,
//   d_writedata                    D-cache block read / writeback request
//   d_readdata, d_busywait         block returned to D-cache, D-cache stall
//   m_read, m_write, m_address,
//   m_writedata                    registered memory request
//   m_readdata, m_busywait         memory response; busywait 1->0 = completion
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_busywait
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} owner_t;

  state_t            state, state_d;
  owner_t            owner, owner_d;
  logic              m_read_d, m_write_d;
  logic [ADDR_W-1:0] m_address_d;
  logic [DATA_W-1:0] m_writedata_d, i_readdata_d, d_readdata_d;
  logic              m_busy_q;

  logic i_req, d_req, grant_i, complete;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Arbitration: a lone requester always wins; ties depend on the build.
`ifdef ARB_ROUND_ROBIN_EN
  assign grant_i = i_req & (~d_req | (owner == OWN_D));
`else
  assign grant_i = i_req & ~d_req;
`endif

  // Completion is the falling edge of memory busywait.
  assign complete = m_busy_q & ~m_busywait;

  // Stalls are released only in the owner's DONE cycle.
  assign i_busywait = i_read & ~((state == DONE) && (owner == OWN_I));
  assign d_busywait = d_req  & ~((state == DONE) && (owner == OWN_D));

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_D;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      i_readdata  <= '0;
      d_readdata  <= '0;
      m_busy_q    <= 1'b0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      m_read      <= m_read_d;
      m_write     <= m_write_d;
      m_address   <= m_address_d;
      m_writedata <= m_writedata_d;
      i_readdata  <= i_readdata_d;
      d_readdata  <= d_readdata_d;
      m_busy_q    <= m_busywait;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d       = state;
    owner_d       = owner;
    m_read_d      = m_read;
    m_write_d     = m_write;
    m_address_d   = m_address;
    m_writedata_d = m_writedata;
    i_readdata_d  = i_readdata;
    d_readdata_d  = d_readdata;

    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          state_d = GRANT;
          if (grant_i) begin
            owner_d     = OWN_I;
            m_read_d    = 1'b1;
            m_address_d = i_address;
          end else begin
            owner_d     = OWN_D;
            m_address_d = d_address;
            // A simultaneous read+write is handled as a writeback.
            if (d_write) begin
              m_write_d     = 1'b1;
              m_writedata_d = d_writedata;
            end else begin
              m_read_d = 1'b1;
            end
          end
        end
      end
      GRANT: begin
        if (complete) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = DONE;
          // Read data lands even if the requester has since withdrawn.
          if (m_read) begin
            if (owner == OWN_I) i_readdata_d = m_readdata;
            else                d_readdata_d = m_readdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter: a behavioural block memory (3-cycle busy per
//   request), a monitor recording every memory request into an observed queue,
//   and directed scenario tasks. Expected memory requests are queued as
//   stimulus is driven and matched in order by test_scoreboard.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read, d_read, d_write;
  logic [ADDR_W-1:0] i_address, d_address, m_address;
  logic [DATA_W-1:0] i_readdata, d_readdata, d_writedata, m_writedata, m_readdata;
  logic              i_busywait, d_busywait, m_read, m_write, m_busywait;

  int   n_cmp = 0;
  int   n_bad = 0;
  txn_t exp_q[$];
  txn_t obs_q[$];

  // Bench-side model state
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] exp_i_rd, exp_d_rd;
  bit                last_i;   // 1 = I-cache granted last

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_busywait(m_busywait)
  );

  always #5 clk = ~clk;

  // Behavioural memory: busy for 3 cycles from the cycle after a new strobe.
  logic mem_busy, strobe_q;
  int   mem_cnt;
  assign m_busywait = mem_busy;
  assign m_readdata = mem_rdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_busy <= 1'b0;
      strobe_q <= 1'b0;
      mem_cnt  <= 0;
    end else begin
      strobe_q <= m_read | m_write;
      if ((m_read | m_write) && !strobe_q) begin
        obs_q.push_back({m_write, m_address, m_write ? m_writedata : {DATA_W{1'b0}}});
        mem_busy <= 1'b1;
        mem_cnt  <= 2;
      end else if (mem_busy) begin
        if (mem_cnt == 0) mem_busy <= 1'b0;
        else              mem_cnt  <= mem_cnt - 1;
      end
    end
  end

  // Waits (bounded) for the given side's busywait to drop; tracks the other side.
  task automatic wait_release(input bit is_i, output int cycles, output bit other_held);
    bit busy;
    cycles     = 0;
    other_held = 1'b1;
    do begin
      @(negedge clk);
      cycles++;
      busy = is_i ? i_busywait : d_busywait;
      if (is_i ? !d_busywait : !i_busywait) other_held = 1'b0;
    end while (busy && cycles < 50);
  endtask

  task automatic test_reset();
    reset = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_writedata = '0; mem_rdata = '0;
    exp_i_rd = '0; exp_d_rd = '0; last_i = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({m_read, m_write} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got=%b exp=00", {m_read, m_write}); end
    n_cmp++; if (m_address !== '0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", m_address); end
    n_cmp++; if (m_writedata !== '0) begin n_bad++; $display("FAIL reset_wdata got=%h exp=0", m_writedata); end
    n_cmp++; if (i_readdata !== '0 || d_readdata !== '0) begin n_bad++; $display("FAIL reset_rdata got=%h/%h exp=0", i_readdata, d_readdata); end
    n_cmp++; if ({i_busywait, d_busywait} !== 2'b00) begin n_bad++; $display("FAIL reset_idle_busy got=%b exp=00", {i_busywait, d_busywait}); end
    i_read = 1'b1; d_write = 1'b1;
    #1;
    n_cmp++; if ({i_busywait, d_busywait} !== 2'b11) begin n_bad++; $display("FAIL reset_follow_req got=%b exp=11", {i_busywait, d_busywait}); end
    i_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    int cyc; bit held;
    i_address = 28'h0000010; mem_rdata = {4{32'hA5A5A5A5}}; i_read = 1'b1;
    exp_q.push_back({1'b0, 28'h0000010, {DATA_W{1'b0}}});
    @(negedge clk);
    n_cmp++; if (m_read !== 1'b1 || m_write !== 1'b0) begin n_bad++; $display("FAIL iread_strobe got=%b%b exp=10", m_read, m_write); end
    n_cmp++; if (m_address !== 28'h0000010) begin n_bad++; $display("FAIL iread_addr got=%h exp=0000010", m_address); end
    wait_release(1'b1, cyc, held);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL iread_latency got=%0d exp=5", cyc); end
    exp_i_rd = {4{32'hA5A5A5A5}};
    n_cmp++; if (i_readdata !== exp_i_rd) begin n_bad++; $display("FAIL iread_data got=%h exp=%h", i_readdata, exp_i_rd); end
    n_cmp++; if (d_readdata !== exp_d_rd) begin n_bad++; $display("FAIL iread_d_untouched got=%h exp=%h", d_readdata, exp_d_rd); end
    n_cmp++; if (m_read !== 1'b0) begin n_bad++; $display("FAIL iread_strobe_clear got=%b exp=0", m_read); end
    i_read = 1'b0; last_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_d_write();
    int cyc; bit held;
    logic [DATA_W-1:0] wd;
    wd = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    d_address = 28'h0000020; d_writedata = wd; d_write = 1'b1; mem_rdata = {4{32'hDEADBEEF}};
    exp_q.push_back({1'b1, 28'h0000020, wd});
    @(negedge clk);
    n_cmp++; if (m_write !== 1'b1 || m_read !== 1'b0) begin n_bad++; $display("FAIL dwrite_strobe got=%b%b exp=01", m_read, m_write); end
    n_cmp++; if (m_writedata !== wd) begin n_bad++; $display("FAIL dwrite_wdata got=%h exp=%h", m_writedata, wd); end
    d_address = 28'h0000999;  // must be ignored once latched
    wait_release(1'b0, cyc, held);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL dwrite_latency got=%0d exp=5", cyc); end
    n_cmp++; if (d_readdata !== exp_d_rd) begin n_bad++; $display("FAIL dwrite_rdata_kept got=%h exp=%h", d_readdata, exp_d_rd); end
    n_cmp++; if (i_readdata !== exp_i_rd) begin n_bad++; $display("FAIL dwrite_i_untouched got=%h exp=%h", i_readdata, exp_i_rd); end
    d_write = 1'b0; last_i = 1'b0;
    @(negedge clk);
  endtask

  // Simultaneous I and D reads; winner follows the configured policy.
  task automatic test_tie(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                          input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2);
    int cyc; bit held; bit i_first;
`ifdef ARB_ROUND_ROBIN_EN
    i_first = !last_i;
`else
    i_first = 1'b0;
`endif
    i_address = ia; d_address = da; mem_rdata = r1;
    i_read = 1'b1; d_read = 1'b1;
    exp_q.push_back({1'b0, i_first ? ia : da, {DATA_W{1'b0}}});
    exp_q.push_back({1'b0, i_first ? da : ia, {DATA_W{1'b0}}});
    wait_release(i_first, cyc, held);
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL tie_first_latency got=%0d exp=6", cyc); end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL tie_loser_stalled got=%b exp=1", held); end
    if (i_first) begin exp_i_rd = r1; i_read = 1'b0; end
    else         begin exp_d_rd = r1; d_read = 1'b0; end
    n_cmp++; if ((i_first ? i_readdata : d_readdata) !== r1) begin n_bad++; $display("FAIL tie_first_data got=%h exp=%h", i_first ? i_readdata : d_readdata, r1); end
    mem_rdata = r2;
    wait_release(!i_first, cyc, held);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL tie_second_latency got=%0d exp=7", cyc); end
    if (i_first) begin exp_d_rd = r2; d_read = 1'b0; end
    else         begin exp_i_rd = r2; i_read = 1'b0; end
    n_cmp++; if (i_readdata !== exp_i_rd || d_readdata !== exp_d_rd) begin n_bad++; $display("FAIL tie_rdata got=%h/%h exp=%h/%h", i_readdata, d_readdata, exp_i_rd, exp_d_rd); end
    last_i = !i_first;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    test_tie(28'h0000030, 28'h0000040, {4{32'h11112222}}, {4{32'h33334444}});
    test_tie(28'h0000031, 28'h0000041, {4{32'h55556666}}, {4{32'h77778888}});
  endtask

  task automatic test_reset_mid_grant();
    int cyc; bit held;
    i_address = 28'h0000050; mem_rdata = {4{32'hC0FFEE00}}; i_read = 1'b1;
    exp_q.push_back({1'b0, 28'h0000050, {DATA_W{1'b0}}});
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (m_read !== 1'b0) begin n_bad++; $display("FAIL rst_mid_mread got=%b exp=0", m_read); end
    n_cmp++; if (i_readdata !== '0 || d_readdata !== '0) begin n_bad++; $display("FAIL rst_mid_rdata got=%h/%h exp=0", i_readdata, d_readdata); end
    n_cmp++; if (i_busywait !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy got=%b exp=1", i_busywait); end
    exp_i_rd = '0; exp_d_rd = '0; last_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({1'b0, 28'h0000050, {DATA_W{1'b0}}});
    wait_release(1'b1, cyc, held);
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL rst_reissue_latency got=%0d exp=6", cyc); end
    exp_i_rd = {4{32'hC0FFEE00}};
    n_cmp++; if (i_readdata !== exp_i_rd) begin n_bad++; $display("FAIL rst_reissue_data got=%h exp=%h", i_readdata, exp_i_rd); end
    i_read = 1'b0; last_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rw_both();
    int cyc; bit held;
    d_address = 28'h0000060; d_writedata = {4{32'h0BADF00D}}; mem_rdata = {4{32'hFFFF0000}};
    d_read = 1'b1; d_write = 1'b1;
    exp_q.push_back({1'b1, 28'h0000060, {4{32'h0BADF00D}}});
    @(negedge clk);
    n_cmp++; if ({m_read, m_write} !== 2'b01) begin n_bad++; $display("FAIL rw_both_strobe got=%b exp=01", {m_read, m_write}); end
    wait_release(1'b0, cyc, held);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL rw_both_latency got=%0d exp=5", cyc); end
    n_cmp++; if (d_readdata !== exp_d_rd) begin n_bad++; $display("FAIL rw_both_rdata got=%h exp=%h", d_readdata, exp_d_rd); end
    d_read = 1'b0; d_write = 1'b0; last_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // In-order match of every memory request seen against the expected list.
  task automatic test_scoreboard();
    txn_t e, o;
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL sb_txn got=wr%b a%h d%h exp=wr%b a%h d%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_back_to_back();
    test_reset_mid_grant();
    test_rw_both();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
